// File: rtl/y86_pkg.sv
// Y86-64 shared encodings: instruction codes, status codes, memory-stage FSM states
// and helpers that classify memory instructions.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic icode_is_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

  function automatic logic icode_is_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
  endfunction

  // popq/ret address the stack through valA; everything else uses the ALU result
  function automatic logic icode_addr_from_vala(input logic [3:0] icode);
    return (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-wide single-port data memory: combinational read, posedge write.
// Contents are deliberately not cleared by reset.
module dmem_ram #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 SEQ memory stage: byte-serial little-endian load/store with start/done handshake.
// Optional out-of-range address fault when DMEM_RANGE_CHECK_EN is defined.
module mem_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [1:0]  stat_in,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [1:0]  stat_out,
  output logic        dmem_err
);

  mem_state_t  state;
  logic [2:0]  cnt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  stat_q;
  logic        fault_q;

  logic              is_rd_c;
  logic              is_wr_c;
  logic              is_mem_c;
  logic [63:0]       sel_addr_c;
  logic [63:0]       sel_wdata_c;
  logic              fault_c;
  logic              go_access_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_we_c;
  logic [7:0]        ram_wdata_c;
  logic [7:0]        ram_rdata_c;

  assign is_rd_c     = icode_is_read(icode);
  assign is_wr_c     = icode_is_write(icode);
  assign is_mem_c    = is_rd_c || is_wr_c;
  assign sel_addr_c  = icode_addr_from_vala(icode) ? valA : valE;
  assign sel_wdata_c = (icode == ICODE_CALL) ? valP : valA;

`ifdef DMEM_RANGE_CHECK_EN
  // The whole 8-byte word must fit: last legal base address is MEM_BYTES-8
  assign fault_c = is_mem_c && (stat_in == STAT_AOK) && (sel_addr_c > 64'(MEM_BYTES - 8));
`else
  assign fault_c = 1'b0;
`endif

  assign go_access_c = is_mem_c && (stat_in == STAT_AOK) && !fault_c;

  // Byte k of the word lives at addr+k, wrapped into the RAM by truncation
  assign ram_addr_c  = ADDR_W'(addr_q + 64'(cnt));
  assign ram_we_c    = (state == ST_ACCESS) && wr_q;
  assign ram_wdata_c = wdata_q[{cnt, 3'b000} +: 8];

  dmem_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr_c),
    .we    (ram_we_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      stat_q   <= STAT_AOK;
      fault_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valM     <= 64'd0;
      stat_out <= STAT_AOK;
      dmem_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= sel_addr_c;
            wdata_q <= sel_wdata_c;
            rd_q    <= is_rd_c && go_access_c;
            wr_q    <= is_wr_c && go_access_c;
            stat_q  <= fault_c ? STAT_ADR : stat_in;
            fault_q <= fault_c;
            cnt     <= 3'd0;
            valM    <= 64'd0;
            busy    <= 1'b1;
            state   <= go_access_c ? ST_ACCESS : ST_DONE;
          end
        end
        ST_ACCESS: begin
          if (rd_q) valM[{cnt, 3'b000} +: 8] <= ram_rdata_c;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_DONE;
        end
        ST_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          stat_out <= stat_q;
          dmem_err <= fault_q;
          state    <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expected results are queued at launch and checked at done.
// Build with or without DMEM_RANGE_CHECK_EN.
module tb_mem_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [1:0]  stat_in;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic [1:0]  stat_out;
  logic        dmem_err;

  typedef struct {
    logic [63:0] valm;
    logic [1:0]  stat;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mem_stage dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .icode    (icode),
    .stat_in  (stat_in),
    .valE     (valE),
    .valA     (valA),
    .valP     (valP),
    .busy     (busy),
    .done     (done),
    .valM     (valM),
    .stat_out (stat_out),
    .dmem_err (dmem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [1:0] st,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    icode   = ic;
    stat_in = st;
    valE    = e;
    valA    = a;
    valP    = p;
    start   = 1'b1;
  endtask

  // Launch one op at a negedge; latency counts posedges from the one that samples start
  task automatic do_op(input string tag, input logic [3:0] ic, input logic [1:0] st,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                       input logic [63:0] xm, input logic [1:0] xs, input logic xe, input int xl);
    exp_t x;
    exp_t got;
    logic seen;
    int   lat;
    x.valm = xm; x.stat = xs; x.err = xe; x.lat = xl;
    sb.push_back(x);
    drive(ic, st, e, a, p);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      got = sb.pop_front();
      chk({tag, "_lat"}, 64'(lat), 64'(got.lat));
      chk({tag, "_valM"}, valM, got.valm);
      chk({tag, "_stat"}, 64'(stat_out), 64'(got.stat));
      chk({tag, "_err"}, 64'(dmem_err), 64'(got.err));
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int pulses;
    logic [63:0] m_at_done;
    exp_t got;

    rst = 1'b1; start = 1'b0; icode = 4'h0; stat_in = STAT_AOK;
    valE = 64'd0; valA = 64'd0; valP = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valM", valM, 64'd0);
    chk("rst_stat", 64'(stat_out), 64'(STAT_AOK));
    chk("rst_err", 64'(dmem_err), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // store then load back a word; RAM is little-endian
    do_op("st40", ICODE_RMMOVQ, STAT_AOK, 64'h40, 64'h1122334455667788, 64'h0,
          64'h0, STAT_AOK, 1'b0, 10);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("ram40", 64'(dut.u_ram.mem[10'h040]), 64'h88);
    chk("ram47", 64'(dut.u_ram.mem[10'h047]), 64'h11);
    do_op("ld40", ICODE_MRMOVQ, STAT_AOK, 64'h40, 64'h0, 64'h0,
          64'h1122334455667788, STAT_AOK, 1'b0, 10);

    // call pushes valP, ret reads it via valA
    do_op("call", ICODE_CALL, STAT_AOK, 64'h100, 64'hDEAD, 64'h2A,
          64'h0, STAT_AOK, 1'b0, 10);
    chk("ram100", 64'(dut.u_ram.mem[10'h100]), 64'h2A);
    chk("ram107", 64'(dut.u_ram.mem[10'h107]), 64'h00);
    do_op("ret", ICODE_RET, STAT_AOK, 64'h0, 64'h100, 64'h0,
          64'h2A, STAT_AOK, 1'b0, 10);

    // non-memory and non-AOK paths skip the access
    do_op("opq", ICODE_OPQ, STAT_AOK, 64'h40, 64'hFFFF, 64'h0,
          64'h0, STAT_AOK, 1'b0, 2);
    chk("ram40_keep", 64'(dut.u_ram.mem[10'h040]), 64'h88);
    do_op("hlt_ld", ICODE_MRMOVQ, STAT_HLT, 64'h40, 64'h0, 64'h0,
          64'h0, STAT_HLT, 1'b0, 2);
    do_op("ins_st", ICODE_PUSHQ, STAT_INS, 64'h40, 64'h0, 64'h0,
          64'h0, STAT_INS, 1'b0, 2);
    chk("ram40_keep2", 64'(dut.u_ram.mem[10'h040]), 64'h88);

    // last fully in-range word
    do_op("st3f8", ICODE_RMMOVQ, STAT_AOK, 64'h3F8, 64'h0102030405060708, 64'h0,
          64'h0, STAT_AOK, 1'b0, 10);
    chk("ram3ff", 64'(dut.u_ram.mem[10'h3FF]), 64'h01);
`ifdef DMEM_RANGE_CHECK_EN
    do_op("ld3f9_adr", ICODE_MRMOVQ, STAT_AOK, 64'h3F9, 64'h0, 64'h0,
          64'h0, STAT_ADR, 1'b1, 2);
    do_op("pop_hi_adr", ICODE_POPQ, STAT_AOK, 64'h0, 64'h1_0000_0000, 64'h0,
          64'h0, STAT_ADR, 1'b1, 2);
`else
    do_op("st3f9_wrap", ICODE_RMMOVQ, STAT_AOK, 64'h3F9, 64'hA1B2C3D4E5F60718, 64'h0,
          64'h0, STAT_AOK, 1'b0, 10);
    chk("ram3f9", 64'(dut.u_ram.mem[10'h3F9]), 64'h18);
    chk("ram3ff_w", 64'(dut.u_ram.mem[10'h3FF]), 64'hB2);
    chk("ram000_w", 64'(dut.u_ram.mem[10'h000]), 64'hA1);
    do_op("ld3f9_wrap", ICODE_MRMOVQ, STAT_AOK, 64'h3F9, 64'h0, 64'h0,
          64'hA1B2C3D4E5F60718, STAT_AOK, 1'b0, 10);
`endif
    do_op("ld3f8", ICODE_MRMOVQ, STAT_AOK, 64'h3F8, 64'h0, 64'h0,
`ifdef DMEM_RANGE_CHECK_EN
          64'h0102030405060708,
`else
          64'hB2C3D4E5F6071808,
`endif
          STAT_AOK, 1'b0, 10);

    // a second start while busy is dropped; exactly one done
    got.valm = 64'h1122334455667788; got.stat = STAT_AOK; got.err = 1'b0; got.lat = 10;
    sb.push_back(got);
    drive(ICODE_MRMOVQ, STAT_AOK, 64'h40, 64'h0, 64'h0);
    pulses = 0;
    m_at_done = 64'hX;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) drive(ICODE_OPQ, STAT_HLT, 64'h0, 64'h0, 64'h0);
      if (done === 1'b1) begin
        pulses++;
        m_at_done = valM;
      end
    end
    start = 1'b0;
    got = sb.pop_front();
    chk("busy_one_done", 64'(pulses), 64'(1));
    chk("busy_valM", m_at_done, got.valm);
    chk("busy_stat", 64'(stat_out), 64'(got.stat));

    // reset during a store: bytes 0..3 stay written
    do_op("zero80", ICODE_RMMOVQ, STAT_AOK, 64'h80, 64'h0, 64'h0,
          64'h0, STAT_AOK, 1'b0, 10);
    drive(ICODE_RMMOVQ, STAT_AOK, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_valM", valM, 64'd0);
    chk("mid_rst_stat", 64'(stat_out), 64'(STAT_AOK));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("ld80", ICODE_MRMOVQ, STAT_AOK, 64'h80, 64'h0, 64'h0,
          64'h0000_0000_FFFF_FFFF, STAT_AOK, 1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
